// File: rtl/color_white_balance.sv
// White-balance calibration for a TCS3200 sensor: steps the filter through red, green, blue,
// counts sensor_out rising edges in a fixed window per colour and latches one reference each.
module color_white_balance #(
  parameter int SETTLE_CYCLES = 1000,
  parameter int WINDOW_CYCLES = 100000,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sensor_out,
  output logic [1:0]       filter_select_balance,
  output logic             ready,
  output logic             busy,
  output logic [CNT_W-1:0] r_ref,
  output logic [CNT_W-1:0] g_ref,
  output logic [CNT_W-1:0] b_ref
);

  localparam int TMR_MAX = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
  localparam int TMR_W   = ($clog2(TMR_MAX) > 0) ? $clog2(TMR_MAX) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, COUNT, DONE} state_t;

  state_t           state, state_next;
  logic [1:0]       ch, ch_next;
  logic [TMR_W-1:0] timer, timer_next;
  logic [CNT_W-1:0] pulses, pulses_next, pulses_inc;
  logic             sync1, sync2, sync3, rise;
  logic             settle_end, window_end, busy_next;

  function automatic logic [1:0] code(input logic [1:0] c);
    case (c)
      2'd0:    code = 2'b00;
      2'd1:    code = 2'b11;
      2'd2:    code = 2'b01;
      default: code = 2'b10;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= sensor_out;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise       = sync2 & ~sync3;
  assign pulses_inc = (rise && pulses != '1) ? pulses + CNT_W'(1) : pulses;
  assign settle_end = (timer == TMR_W'(SETTLE_CYCLES - 1));
  assign window_end = (timer == TMR_W'(WINDOW_CYCLES - 1));

  always_comb begin
    state_next  = state;
    ch_next     = ch;
    timer_next  = timer;
    pulses_next = pulses;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = SETTLE;
          ch_next    = 2'd0;
          timer_next = '0;
        end
      end
      SETTLE: begin
        if (settle_end) begin
          state_next  = COUNT;
          timer_next  = '0;
          pulses_next = '0;
        end else begin
          timer_next = timer + TMR_W'(1);
        end
      end
      COUNT: begin
        pulses_next = pulses_inc;
        if (window_end) begin
          timer_next = '0;
          if (ch == 2'd2) begin
            state_next = DONE;
          end else begin
            state_next = SETTLE;
            ch_next    = ch + 2'd1;
          end
        end else begin
          timer_next = timer + TMR_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy_next = (state_next == SETTLE) || (state_next == COUNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ch     <= 2'd0;
      timer  <= '0;
      pulses <= '0;
    end else begin
      state  <= state_next;
      ch     <= ch_next;
      timer  <= timer_next;
      pulses <= pulses_next;
    end
  end

  // busy/filter follow the next state so they switch on the start edge; ready lags DONE by one clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      filter_select_balance <= 2'b10;
      ready                 <= 1'b0;
      busy                  <= 1'b0;
      r_ref                 <= '0;
      g_ref                 <= '0;
      b_ref                 <= '0;
    end else begin
      busy                  <= busy_next;
      filter_select_balance <= busy_next ? code(ch_next) : 2'b10;
      ready                 <= (state == DONE) && !start;
      if (state == COUNT && window_end) begin
        case (ch)
          2'd0:    r_ref <= pulses_inc;
          2'd1:    g_ref <= pulses_inc;
          default: b_ref <= pulses_inc;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_color_white_balance.sv
// Directed bench for color_white_balance: idle/reset, nominal run, per-channel rates,
// saturation on a narrow-counter instance, ignored/accepted restarts and mid-run reset.
module tb_color_white_balance;

  localparam int S = 4;
  localparam int W = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       sensor = 1'b0;
  logic       sensor_sat = 1'b0;
  logic [1:0] filter;
  logic       ready, busy;
  logic [7:0] r_ref, g_ref, b_ref;
  logic [1:0] filter_sat;
  logic       ready_sat, busy_sat;
  logic [3:0] r_sat, g_sat, b_sat;

  int checks = 0;
  int errors = 0;
  int per_fixed = 10;
  bit per_chan = 1'b0;
  int phase = 0;

  color_white_balance #(.SETTLE_CYCLES(S), .WINDOW_CYCLES(W), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .sensor_out(sensor),
    .filter_select_balance(filter), .ready(ready), .busy(busy),
    .r_ref(r_ref), .g_ref(g_ref), .b_ref(b_ref)
  );

  color_white_balance #(.SETTLE_CYCLES(S), .WINDOW_CYCLES(W), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .sensor_out(sensor_sat),
    .filter_select_balance(filter_sat), .ready(ready_sat), .busy(busy_sat),
    .r_ref(r_sat), .g_ref(g_sat), .b_ref(b_sat)
  );

  always #5 clk = ~clk;

  // Sensor model: square wave whose period is fixed or chosen from the current filter code.
  always @(negedge clk) begin
    int per;
    per = per_fixed;
    if (per_chan) begin
      case (filter)
        2'b00:   per = 4;
        2'b11:   per = 10;
        2'b01:   per = 20;
        default: per = 10;
      endcase
    end
    if (phase >= per - 1) phase = 0;
    else phase = phase + 1;
    sensor     = (phase < per / 2);
    sensor_sat = ~sensor_sat;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int got, input int exp, input int tol = 0);
    checks++;
    if (got < exp - tol || got > exp + tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  // Pulse start, optionally re-pulse start at cycle inject_at, and wait for ready.
  task automatic run(input int inject_at);
    int n = 0;
    int n_r = 0, n_g = 0, n_b = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("filter_after_start", filter, 0);
    check("ready_after_start", ready, 0);
    while (!ready && n < 2000) begin
      case (filter)
        2'b00: n_r++;
        2'b11: n_g++;
        2'b01: n_b++;
        default: ;
      endcase
      if (n == 104) check("filter_green", filter, 3);
      if (n == 208) check("filter_blue", filter, 1);
      if (n == inject_at) start = 1'b1;
      tick();
      start = 1'b0;
      n++;
    end
    check("ready_latency", n, 3 * (S + W) + 1);
    check("red_cycles", n_r, S + W);
    check("green_cycles", n_g, S + W);
    check("blue_cycles", n_b, S + W);
    check("busy_done", busy, 0);
    check("filter_done", filter, 2);
  endtask

  initial begin
    bit bad;
    int n;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_filter", filter, 2);
    check("rst_ready", ready, 0);
    check("rst_busy", busy, 0);
    check("rst_refs", r_ref | g_ref | b_ref, 0);

    bad = 1'b0;
    repeat (50) begin
      tick();
      if (filter != 2'b10 || ready || busy || (r_ref | g_ref | b_ref) != 0) bad = 1'b1;
    end
    check("idle_hold", bad, 0);

    // Nominal run, period 10
    per_fixed = 10;
    run(-1);
    check("nom_r", r_ref, 10, 1);
    check("nom_g", g_ref, 10, 1);
    check("nom_b", b_ref, 10, 1);
    check("sat_ready", ready_sat, 1);
    check("sat_r", r_sat, 15);
    check("sat_g", g_sat, 15);
    check("sat_b", b_sat, 15);

    // Different rate per filter
    per_chan = 1'b1;
    run(-1);
    per_chan = 1'b0;
    check("chan_r", r_ref, 25, 1);
    check("chan_g", g_ref, 10, 1);
    check("chan_b", b_ref, 5, 1);

    // Start mid-green is ignored; latency check in run covers the unchanged timing
    run(150);
    check("ign_g", g_ref, 10, 1);

    // Start from DONE with a new rate
    per_fixed = 5;
    run(-1);
    check("rerun_r", r_ref, 20, 1);
    check("rerun_g", g_ref, 20, 1);
    check("rerun_b", b_ref, 20, 1);

    // Reset during the blue counting window
    per_fixed = 10;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (filter != 2'b01 && n < 1000) begin
      tick();
      n++;
    end
    check("reach_blue", filter, 1);
    repeat (30) tick();
    check("busy_in_blue", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_filter", filter, 2);
    check("midrst_ready", ready, 0);
    check("midrst_busy", busy, 0);
    check("midrst_r", r_ref, 0);
    check("midrst_g", g_ref, 0);
    check("midrst_b", b_ref, 0);
    tick();
    run(-1);
    check("post_r", r_ref, 10, 1);
    check("post_g", g_ref, 10, 1);
    check("post_b", b_ref, 10, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
